ifid_queue: RTL and testbench

IFID_QUEUE -- requirements
Module: ifid_queue

---
 rtl/ifid_pkg.sv | 20 ++
 rtl/ifid_ptr_ctrl.sv | 79 +++++++
 rtl/ifid_queue.sv | 68 ++++++
 tb/tb_ifid_queue.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ifid_pkg.sv
// Shared constants and helpers for the IF/ID instruction queue.
package ifid_pkg;

  localparam int unsigned PC_W_DEF    = 32;
  localparam int unsigned INSTR_W_DEF = 32;

  // All-zero encoding is presented to ID as a bubble when the queue is empty.
  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

  // Ceiling log2, used to size pointers and the occupancy counter.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ifid_ptr_ctrl.sv
// Read/write pointer and occupancy control for the IF/ID queue.
module ifid_ptr_ctrl
  import ifid_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push_req,
  input  logic                    pop_req,
  output logic                    push_en,
  output logic                    pop_en,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [clog2(DEPTH)-1:0] rd_ptr,
  output logic [clog2(DEPTH)-1:0] wr_ptr,
  output logic [clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Handshake qualification: full blocks push even if a pop happens the same cycle.
  always_comb begin
    in_ready  = (count_q < FullCnt);
    out_valid = (count_q != '0);
    push_en   = push_req & in_ready & ~flush;
    pop_en    = pop_req & out_valid & ~flush;
  end

  // Next-state for pointers and occupancy; flush overrides any handshake.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop_en) begin
        rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_ptr = rd_ptr_q;
  assign wr_ptr = wr_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/ifid_queue.sv
// IF/ID decoupling queue: FIFO of fetched (PC, instruction) pairs feeding decode.
module ifid_queue
  import ifid_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [INSTR_W-1:0]   in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [INSTR_W-1:0]   out_instr,
  output logic [clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = clog2(DEPTH);

  logic            push_en;
  logic            pop_en;
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW-1:0] wr_ptr;

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  ifid_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push_req  (in_valid),
    .pop_req   (out_ready),
    .push_en   (push_en),
    .pop_en    (pop_en),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .rd_ptr    (rd_ptr),
    .wr_ptr    (wr_ptr),
    .count     (count)
  );

  // Storage write; contents are not reset since occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push_en) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  // Head read mux; an empty queue presents a zero-PC NOP bubble.
  always_comb begin
    out_pc    = '0;
    out_instr = INSTR_W'(NOP_INSTR);
    if (out_valid) begin
      out_pc    = pc_mem[rd_ptr];
      out_instr = instr_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_ifid_queue.sv
// Self-checking bench for ifid_queue: queue-based reference model plus directed scenarios.
module tb_ifid_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int n_checks;
  int n_err;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t mq[$];

  ifid_queue #(
    .PC_W    (32),
    .INSTR_W (32),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO; full/empty judged on occupancy before the edge.
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      if (flush) begin
        mq.delete();
      end else begin
        int sz;
        sz = mq.size();
        if (out_ready && sz > 0) void'(mq.pop_front());
        if (in_valid && sz < DEPTH) mq.push_back('{pc: in_pc, instr: in_instr});
      end
    end
  end

  always @(negedge reset) mq.delete();

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [31:0] e_pc, e_instr;
    e_pc    = '0;
    e_instr = '0;
    if (mq.size() > 0) begin
      e_pc    = mq[0].pc;
      e_instr = mq[0].instr;
    end
    check("model_count", 64'(count), 64'(mq.size()));
    check("model_out_valid", 64'(out_valid), 64'(mq.size() > 0));
    check("model_in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
    check("model_out_pc", 64'(out_pc), 64'(e_pc));
    check("model_out_instr", 64'(out_instr), 64'(e_instr));
  end

  // Apply one cycle of inputs, then return 1 time unit after the capturing edge.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_err     = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);

    // In-order push/pop with ID always ready: each entry appears one cycle after push.
    drive(1'b1, 32'h00, 32'h20080001, 1'b1, 1'b0);
    check("inord_pc0", 64'(out_pc), 64'h00);
    check("inord_ins0", 64'(out_instr), 64'h20080001);
    drive(1'b1, 32'h04, 32'h20080002, 1'b1, 1'b0);
    check("inord_pc1", 64'(out_pc), 64'h04);
    drive(1'b1, 32'h08, 32'h20080003, 1'b1, 1'b0);
    check("inord_pc2", 64'(out_pc), 64'h08);
    check("inord_ins2", 64'(out_instr), 64'h20080003);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("inord_empty", 64'(out_valid), 64'd0);

    // Fill to full with ID stalled; fifth push must be dropped.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(4 * i), 32'h10000000 + 32'(i), 1'b0, 1'b0);
      if (i == 3) check("full_in_ready", 64'(in_ready), 64'd0);
    end
    check("full_count", 64'(count), 64'd4);
    check("full_head_pc", 64'(out_pc), 64'h00);

    // At full: pop only, then push+pop holds count.
    drive(1'b1, 32'h14, 32'h10000005, 1'b1, 1'b0);
    check("fullpop_count", 64'(count), 64'd3);
    check("fullpop_pc", 64'(out_pc), 64'h04);
    drive(1'b1, 32'h18, 32'h10000006, 1'b1, 1'b0);
    check("pushpop_count", 64'(count), 64'd3);
    check("pushpop_pc", 64'(out_pc), 64'h08);

    // Flush with a concurrent push: everything discarded.
    drive(1'b1, 32'h1c, 32'h10000007, 1'b0, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_instr", 64'(out_instr), 64'd0);

    // Interleaved push/pop across several pointer wraps.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'h30000000 + 32'(i), 1'b0, 1'b0);
      check("wrap_pc", 64'(out_pc), 64'(32'h100 + 32'(4 * i)));
      check("wrap_cnt1", 64'(count), 64'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("wrap_cnt0", 64'(count), 64'd0);
    end

    // Asynchronous reset between edges with two entries queued.
    drive(1'b1, 32'h200, 32'h40000000, 1'b0, 1'b0);
    drive(1'b1, 32'h204, 32'h40000001, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("prerst_count", 64'(count), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_pc", 64'(out_pc), 64'd0);
    check("arst_instr", 64'(out_instr), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("rel_in_ready", 64'(in_ready), 64'd1);
    check("rel_count", 64'(count), 64'd0);
    drive(1'b1, 32'h300, 32'h50000000, 1'b0, 1'b0);
    check("postrst_pc", 64'(out_pc), 64'h300);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("postrst_empty", 64'(count), 64'd0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
